// File: rtl/bitplane_slicer_pkg.sv
// bitplane_slicer_pkg
// Shared definitions for the bit-plane slicer that feeds the BitBlade
// precision mux-fusion stage.
//   DW        packed operand word width per side
//   MUX_FUS   highest fusion-mux input index; the plane width is MUX_FUS+1
//   PW        bit-plane width
//   PREC_*    2-bit precision codes (code 2'b11 decodes as 2-bit)
//   state_t   slicer FSM encoding
//   width_of  precision code -> operand width in bits (2/4/8)
//   count_of  precision code -> operands per packed word (16/8/4)
package bitplane_slicer_pkg;

  localparam int DW      = 32;
  localparam int MUX_FUS = 15;
  localparam int PW      = MUX_FUS + 1;

  localparam logic [1:0] PREC_2B = 2'b00;
  localparam logic [1:0] PREC_4B = 2'b01;
  localparam logic [1:0] PREC_8B = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // The unused code 2'b11 falls into the default arm, so it acts as 2-bit.
  function automatic logic [3:0] width_of(input logic [1:0] code);
    case (code)
      PREC_4B: return 4'd4;
      PREC_8B: return 4'd8;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic [4:0] count_of(input logic [1:0] code);
    case (code)
      PREC_4B: return 5'd8;
      PREC_8B: return 5'd4;
      default: return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/bitplane_slicer_if.sv
// bitplane_slicer_if
// Groups the upstream word-pair handshake and the downstream plane-pair
// handshake of the bit-plane slicer.
//   Precision, in_valid, in_I, in_W    upstream -> slicer
//   in_ready                           slicer -> upstream
//   out_ready                          downstream -> slicer
//   out_valid, I_PLANE, W_PLANE,
//   SHIFT, LAST, Precision_out         slicer -> downstream
// Modports:
//   master  the environment around the slicer (producer and consumer)
//   slave   the slicer itself
interface bitplane_slicer_if;
  import bitplane_slicer_pkg::*;

  logic [3:0]    Precision;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_I;
  logic [DW-1:0] in_W;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] I_PLANE;
  logic [PW-1:0] W_PLANE;
  logic [3:0]    SHIFT;
  logic          LAST;
  logic [3:0]    Precision_out;

  modport master (
    output Precision, in_valid, in_I, in_W, out_ready,
    input  in_ready, out_valid, I_PLANE, W_PLANE, SHIFT, LAST, Precision_out
  );

  modport slave (
    input  Precision, in_valid, in_I, in_W, out_ready,
    output in_ready, out_valid, I_PLANE, W_PLANE, SHIFT, LAST, Precision_out
  );

endinterface

// File: rtl/bitplane_slicer_extract.sv
// bitplane_slicer_extract
// Purely combinational plane extractor: pulls bit 'bit_idx' out of every
// operand packed in 'word' at the width selected by 'code' and lines the
// bits up as one PW-bit plane (operand k -> plane bit k). Lanes beyond the
// operand count read as 0.
//   word     in  DW  packed operands, operand k at [k*w +: w]
//   code     in  2   precision code (2'b11 behaves as 2-bit)
//   bit_idx  in  3   bit position inside each operand
//   plane    out PW  extracted bit-plane
module bitplane_slicer_extract
  import bitplane_slicer_pkg::*;
(
  input  logic [DW-1:0] word,
  input  logic [1:0]    code,
  input  logic [2:0]    bit_idx,
  output logic [PW-1:0] plane
);

  logic [3:0] width;
  logic [4:0] count;

  assign width = width_of(code);
  assign count = count_of(code);

  // Each plane bit is a 32:1 mux on word; the bit position is kept 5 bits
  // wide so lanes past the operand count never form an out-of-range index,
  // they are simply forced to 0.
  always_comb begin
    plane = '0;
    for (int k = 0; k < PW; k++) begin
      logic [4:0] pos;
      pos = 5'(k * int'(width)) + {2'b00, bit_idx};
      if (k < int'(count)) begin
        plane[k] = word[pos];
      end
    end
  end

endmodule

// File: rtl/bitplane_slicer.sv
// bitplane_slicer
// Operand feeder for the BitBlade mux-fusion stage. Latches one packed
// activation word and one packed weight word, then issues every
// (activation bit i, weight bit j) plane pair, i inner and j outer, with the
// shift amount i+j the downstream shift-add needs.
//   CLK   in  clock
//   RSTn  in  asynchronous active-low reset
//   bus   slave modport of bitplane_slicer_if (both handshakes, planes,
//         SHIFT, LAST and the latched Precision_out)
// Build option:
//   SLICER_B2B_EN  when defined, a new pair may be accepted on the cycle
//                  the LAST beat hands off, removing the idle bubble
//                  between transactions.
module bitplane_slicer
  import bitplane_slicer_pkg::*;
(
  input  logic CLK,
  input  logic RSTn,
  bitplane_slicer_if.slave bus
);

  state_t        state, state_nxt;
  logic [2:0]    i_cnt, i_nxt;
  logic [2:0]    j_cnt, j_nxt;
  logic [DW-1:0] word_i, word_w;
  logic [3:0]    prec;

  logic [3:0]    w_i, w_w;
  logic          i_last, j_last;
  logic          beat_last;
  logic          accept;
  logic          fire_out;
  logic [PW-1:0] plane_i, plane_w;

  // Widths come from the latched precision, so changes on the Precision
  // input while a transaction is issuing have no effect.
  assign w_i       = width_of(prec[1:0]);
  assign w_w       = width_of(prec[3:2]);
  assign i_last    = ({1'b0, i_cnt} == (w_i - 4'd1));
  assign j_last    = ({1'b0, j_cnt} == (w_w - 4'd1));
  assign beat_last = (state == ISSUE) && i_last && j_last;
  assign fire_out  = (state == ISSUE) && bus.out_ready;
  assign accept    = bus.in_valid && bus.in_ready;

`ifdef SLICER_B2B_EN
  // Accept the next pair in the same cycle the final beat leaves.
  assign bus.in_ready = (state == IDLE) || (beat_last && bus.out_ready);
`else
  assign bus.in_ready = (state == IDLE);
`endif

  // Next-state and counter update. An accept always restarts the counters;
  // in the back-to-back build it can coincide with the LAST handshake and
  // then takes priority so the slicer stays in ISSUE.
  always_comb begin
    state_nxt = state;
    i_nxt     = i_cnt;
    j_nxt     = j_cnt;
    if (accept) begin
      state_nxt = ISSUE;
      i_nxt     = 3'd0;
      j_nxt     = 3'd0;
    end else if (fire_out) begin
      if (beat_last) begin
        state_nxt = IDLE;
        i_nxt     = 3'd0;
        j_nxt     = 3'd0;
      end else if (!i_last) begin
        i_nxt = i_cnt + 3'd1;
      end else begin
        i_nxt = 3'd0;
        j_nxt = j_cnt + 3'd1;
      end
    end
  end

  // State, counters and the operand/precision latches. Reset drops any
  // transaction in flight and clears everything visible downstream.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state  <= IDLE;
      i_cnt  <= 3'd0;
      j_cnt  <= 3'd0;
      word_i <= '0;
      word_w <= '0;
      prec   <= 4'd0;
    end else begin
      state <= state_nxt;
      i_cnt <= i_nxt;
      j_cnt <= j_nxt;
      if (accept) begin
        word_i <= bus.in_I;
        word_w <= bus.in_W;
        prec   <= bus.Precision;
      end
    end
  end

  bitplane_slicer_extract u_extract_i (
    .word    (word_i),
    .code    (prec[1:0]),
    .bit_idx (i_cnt),
    .plane   (plane_i)
  );

  bitplane_slicer_extract u_extract_w (
    .word    (word_w),
    .code    (prec[3:2]),
    .bit_idx (j_cnt),
    .plane   (plane_w)
  );

  // Planes are gated with out_valid so the stale words of a finished
  // transaction do not show on the fusion mux inputs while idle.
  assign bus.out_valid     = (state == ISSUE);
  assign bus.I_PLANE       = bus.out_valid ? plane_i : '0;
  assign bus.W_PLANE       = bus.out_valid ? plane_w : '0;
  assign bus.SHIFT         = {1'b0, i_cnt} + {1'b0, j_cnt};
  assign bus.LAST          = beat_last;
  assign bus.Precision_out = prec;

endmodule

// File: tb/tb_bitplane_slicer.sv
// tb_bitplane_slicer
// Self-checking bench for bitplane_slicer. Expected plane pairs come from a
// behavioural model that enumerates (i, j) with plain loops and reads
// operand bits by arithmetic on the packed words.
module tb_bitplane_slicer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bitplane_slicer_if bus();

  bitplane_slicer dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] q_i[$];
  logic [15:0] q_w[$];
  int          q_s[$];
  bit          q_l[$];

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int widthOf(input logic [1:0] code);
    if (code == 2'b01) return 4;
    if (code == 2'b10) return 8;
    return 2;
  endfunction

  function automatic logic [15:0] planeOf(input logic [31:0] word, input int w, input int b);
    logic [15:0] p;
    p = '0;
    for (int k = 0; k < 32 / w; k++) p[k] = word[k * w + b];
    return p;
  endfunction

  // Expected beat list of one transaction: j outer, i inner.
  task automatic buildModel(input logic [3:0] prec, input logic [31:0] vi, input logic [31:0] vw);
    int wi, ww;
    wi = widthOf(prec[1:0]);
    ww = widthOf(prec[3:2]);
    q_i.delete(); q_w.delete(); q_s.delete(); q_l.delete();
    for (int j = 0; j < ww; j++) begin
      for (int i = 0; i < wi; i++) begin
        q_i.push_back(planeOf(vi, wi, i));
        q_w.push_back(planeOf(vw, ww, j));
        q_s.push_back(i + j);
        q_l.push_back((i == wi - 1) && (j == ww - 1));
      end
    end
  endtask

  // Drives one transaction and checks every cycle that out_valid is shown.
  // mode 0: out_ready always 1, 1: toggles 1/0, 2: random.
  // abortAfter >= 0 stops after that many handshakes, leaving it in flight.
  task automatic applyStimulus(input logic [3:0] prec, input logic [31:0] vi, input logic [31:0] vw,
                               input int mode, input int abortAfter);
    int total, beat, cyc;
    bit rdy;
    buildModel(prec, vi, vw);
    total = q_i.size();
    @(negedge clk);
    bus.Precision = prec;
    bus.in_I      = vi;
    bus.in_W      = vw;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.Precision = 4'($urandom);
    bus.in_I      = $urandom;
    bus.in_W      = $urandom;
    beat = 0;
    cyc  = 0;
    while (beat < total && cyc < 400) begin
      if (abortAfter >= 0 && beat == abortAfter) break;
      checkOutput("out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("I_PLANE", 32'(bus.I_PLANE), 32'(q_i[beat]));
      checkOutput("W_PLANE", 32'(bus.W_PLANE), 32'(q_w[beat]));
      checkOutput("SHIFT", 32'(bus.SHIFT), 32'(q_s[beat]));
      checkOutput("LAST", 32'(bus.LAST), 32'(q_l[beat]));
      checkOutput("Precision_out", 32'(bus.Precision_out), 32'(prec));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      bus.out_ready = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) beat++;
    end
    bus.out_ready = 1'b0;
    if (abortAfter < 0) begin
      checkOutput("beats_done", 32'(beat), 32'(total));
      checkOutput("end_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("end_in_ready", 32'(bus.in_ready), 32'd1);
    end
  endtask

  // Holds in_valid high for two identical 2b x 2b pairs and measures the
  // span from the first valid beat to the last handshake.
  task automatic applyB2B();
    int accepts, hs, first_v, last_hs, cyc, span_exp;
    buildModel(4'b0000, 32'h3, 32'h1);
`ifdef SLICER_B2B_EN
    span_exp = 8;
`else
    span_exp = 9;
`endif
    accepts = 0; hs = 0; first_v = -1; last_hs = -1; cyc = 0;
    @(negedge clk);
    bus.Precision = 4'b0000;
    bus.in_I      = 32'h3;
    bus.in_W      = 32'h1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    while (hs < 8 && cyc < 100) begin
      if (bus.in_valid && bus.in_ready) accepts++;
      if (bus.out_valid) begin
        if (first_v < 0) first_v = cyc;
        checkOutput("b2b_I_PLANE", 32'(bus.I_PLANE), 32'(q_i[hs % 4]));
        checkOutput("b2b_SHIFT", 32'(bus.SHIFT), 32'(q_s[hs % 4]));
        checkOutput("b2b_LAST", 32'(bus.LAST), 32'(q_l[hs % 4]));
        hs++;
        last_hs = cyc;
      end
      @(negedge clk);
      cyc++;
      if (accepts == 2) bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b0;
    checkOutput("b2b_handshakes", 32'(hs), 32'd8);
    checkOutput("b2b_accepts", 32'(accepts), 32'd2);
    checkOutput("b2b_span", 32'(last_hs - first_v + 1), 32'(span_exp));
    checkOutput("b2b_end_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.Precision = 4'd0;
    bus.in_valid  = 1'b0;
    bus.in_I      = '0;
    bus.in_W      = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_I_PLANE", 32'(bus.I_PLANE), 32'd0);
    checkOutput("rst_SHIFT", 32'(bus.SHIFT), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset_LAST", 32'(bus.LAST), 32'd0);
    checkOutput("reset_W_PLANE", 32'(bus.W_PLANE), 32'd0);
    checkOutput("reset_Precision_out", 32'(bus.Precision_out), 32'd0);

    // Directed cases from the bring-up plan.
    applyStimulus(4'b0000, 32'h3, 32'h1, 0, -1);
    applyStimulus(4'b1010, 32'h80, 32'h8000_0000, 0, -1);
    applyStimulus(4'b0110, $urandom, $urandom, 1, -1);

    // Reset in the middle of an 8b x 8b transaction.
    applyStimulus(4'b1010, $urandom, $urandom, 0, 5);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_LAST", 32'(bus.LAST), 32'd0);
    checkOutput("midrst_SHIFT", 32'(bus.SHIFT), 32'd0);
    checkOutput("midrst_I_PLANE", 32'(bus.I_PLANE), 32'd0);
    checkOutput("midrst_W_PLANE", 32'(bus.W_PLANE), 32'd0);
    checkOutput("midrst_Precision_out", 32'(bus.Precision_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    applyStimulus(4'b1111, $urandom, $urandom, 0, -1);

    // Randomized transactions with random backpressure.
    for (int t = 0; t < 10; t++) begin
      applyStimulus(4'($urandom), $urandom, $urandom, 2, -1);
    end

    applyB2B();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitplane_slicer.md
Name: bitplane_slicer

Overview:
- Operand feeder that sits directly upstream of the precision mux-fusion stage in the BitBlade 1-bit datapath.
- Accepts one packed 32-bit activation word and one packed 32-bit weight word per transaction.
- Decomposes them into 1-bit planes and issues every (I-plane, W-plane) pair bit-serially.
- Each issued pair carries the shift amount the downstream shift-add needs, so the 16-bit I/W plane outputs drive the fusion mux inputs directly.

Parameters:
- DW, 32, packed operand word width per side (fixed 16 lanes x 2b / 8 x 4b / 4 x 8b)
- PW, 16, plane width (= MUX_FUS+1)

Ports:
- CLK  in  1  clock
- RSTn  in  1  asynchronous active-low reset
- Precision  in  4  [3:2] weight width, [1:0] activation width; 00=2b, 01=4b, 10=8b, 11 treated as 00; sampled on input accept
- in_valid  in  1  input word pair valid
- in_ready  out  1  slicer can accept a pair
- in_I  in  DW  packed activations, operand k in bits [k*wI +: wI]
- in_W  in  DW  packed weights, operand k in bits [k*wW +: wW]
- out_valid  out  1  plane pair valid
- out_ready  in  1  downstream accepts plane pair
- I_PLANE  out  PW  activation bit-plane
- W_PLANE  out  PW  weight bit-plane
- SHIFT  out  4  i+j, range 0..14
- LAST  out  1  final pair of the transaction
- Precision_out  out  4  latched Precision; feeds the fusion mux select

Behaviour:
- Widths:
  - wI = 2/4/8 from Precision[1:0]; wW likewise from [3:2].
  - Operand counts: nI = 32/wI = 16/8/4; nW likewise.
- Plane generation:
  - I_PLANE[k] = bit i of activation operand k, for k < nI; upper bits 0.
  - W_PLANE[k] = bit j of weight operand k, for k < nW; upper bits 0.
- States: IDLE, ISSUE.
  - IDLE: in_ready=1, out_valid=0. On in_valid: latch in_I, in_W, Precision; set i=0, j=0; go to ISSUE. Data is registered, so out_valid rises the cycle after accept (1-cycle latency).
  - ISSUE: in_ready=0 (see optional feature), out_valid=1, outputs held stable until out_ready.
- Advance on out_valid & out_ready:
  - if i < wI-1: i++
  - else: i=0 and j++
  - Order: inner loop i (activation bit), outer loop j (weight bit).
  - Total beats = wI*wW (4..64).
- SHIFT = i+j, combinational from the held counters.
- LAST=1 iff i==wI-1 and j==wW-1.
- Handshake of the LAST beat returns to IDLE; one bubble cycle before the next accept.
- Downstream stall: out_valid held with all outputs stable; no counter change.
- Precision changes while in ISSUE are ignored until the next accept.
- Reset (asynchronous, any state, including mid-transaction): state=IDLE, i=j=0, out_valid=0, LAST=0, SHIFT=0, I_PLANE=W_PLANE=0, Precision_out=0, latched words=0. in_ready=1 once RSTn deasserts.
- No partial-transaction recovery; the transaction is simply dropped on reset.

Optional Feature:
- Macro: SLICER_B2B_EN
- Enabled:
  - in_ready is also 1 in ISSUE when LAST & out_ready.
  - A pair accepted in that cycle loads directly, with i=j=0 and new Precision.
  - State stays ISSUE, giving zero bubble between transactions.
- Disabled: behaviour exactly as above, with one idle cycle between transactions.

Decomposition:
- Shared package/header holds:
  - precision code constants PREC_2B=2'b00, PREC_4B=2'b01, PREC_8B=2'b10
  - a width-decode function (code -> wI, code -> nI)
  - state encoding
  - PW tied to MUX_FUS+1
- Natural sub-module: bitplane_extract, combinational, instantiated twice (I and W). It takes the word, width code and bit index, and returns the PW-bit plane.
- The top module keeps the FSM, counters and registers.

Test Plan:
- Precision=4'b00_00, in_I=32'h3, in_W=32'h1 -> 4 beats:
  - beat 0: I=0001, W=0001, SHIFT 0
  - beat 1: I=0001, W=0001, SHIFT 1
  - beat 2: I=0001, W=0000, SHIFT 1
  - beat 3: I=0001, W=0000, SHIFT 2, LAST=1
- Precision=4'b10_10, in_I=32'h80, in_W=32'h8000_0000 -> 64 beats:
  - I_PLANE=0001 only when i=7; W_PLANE=0008 only when j=7.
  - LAST only on beat 63, with SHIFT=14.
- Precision=4'b01_10, out_ready toggling 1/0 every cycle -> 32 accepted beats; outputs stable across stall cycles; SHIFT sequence 0..7, 1..8, 2..9, 3..10.
- Reset asserted on beat 5 of an 8b x 8b transaction:
  - all outputs 0 and in_ready=1 after deassert
  - the next transaction with Precision=4'b11_11 behaves as 2b x 2b (4 beats)
- Two back-to-back 2b x 2b transactions with in_valid held high:
  - without SLICER_B2B_EN: 9 cycles from first out_valid to last handshake, one bubble
  - with SLICER_B2B_EN: 8 cycles, no bubble
